// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: converter FSM states,
// score/BCD widths and the active-low seven-segment lookup table.
package score_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int MAX_SCORE = 9999;
  localparam int BIN_W     = 14;
  localparam int BCD_W     = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // {g,f,e,d,c,b,a}, active-low; codes 10..15 show nothing
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };
endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one bit per cycle, result
// published to bcd in the DONE state.
module bin2bcd_seq
  import score_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  state_t           state, state_nxt;
  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd_sh, bcd_adj;
  logic [3:0]       cnt;

  always_comb begin
    bcd_adj = bcd_sh;
    for (int i = 0; i < 4; i++)
      if (bcd_sh[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'(BIN_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Shift registers need no reset: they are always reloaded on capture
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        bin_sh <= bin;
        bcd_sh <= '0;
        cnt    <= '0;
      end
      SHIFT: begin
        bcd_sh <= {bcd_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
        bin_sh <= {bin_sh[BIN_W-2:0], 1'b0};
        cnt    <= cnt + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)             bcd <= '0;
    else if (state == DONE) bcd <= bcd_sh;
  end
endmodule

// File: rtl/score_display.sv
// Clamps the game score to four digits, re-converts it to BCD on change and
// time-multiplexes the digits onto a shared active-low seven-segment bus.
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      score,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             dp,
  output logic [BCD_W-1:0] bcd,
  output logic             busy
);
  localparam int CW = $clog2(REFRESH_DIV);

  function automatic logic [BIN_W-1:0] sat_score(input logic [31:0] s);
    return (s > 32'(MAX_SCORE)) ? BIN_W'(MAX_SCORE) : s[BIN_W-1:0];
  endfunction

  logic [BIN_W-1:0] value, cap_value, last_value;
  logic             start, done;
  logic [CW-1:0]    refresh_cnt;
  logic [1:0]       idx;
  logic [3:0]       digit, lz;
  logic             blank;

  assign value = sat_score(score);
  assign start = (value != last_value);
  assign dp    = 1'b1;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  // cap_value mirrors the converter's capture so last_value tracks what was shown
  always_ff @(posedge clk) begin
    if (start && !busy) cap_value <= value;
  end

  always_ff @(posedge clk) begin
    if (!reset)    last_value <= '0;
    else if (done) last_value <= cap_value;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      idx         <= idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  // lz[i]: nibbles i..3 are all zero
  always_comb begin
    lz[3] = (bcd[15:12] == 4'd0);
    lz[2] = lz[3] && (bcd[11:8] == 4'd0);
    lz[1] = lz[2] && (bcd[7:4] == 4'd0);
    lz[0] = lz[1] && (bcd[3:0] == 4'd0);
    digit = bcd[{idx, 2'b00} +: 4];
    blank = BLANK_LEADING && (idx != 2'd0) && lz[idx];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= blank ? SEG_BLANK : SEG_LUT[digit];
    end
  end
endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: directed scenarios plus a randomized run against
// an arithmetic reference model of the displayed value and scan position.
module tb_score_display;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] score = 32'd1234;
  logic [6:0]  seg, seg0;
  logic [3:0]  an, an0;
  logic        dp, dp0, busy, busy0;
  logic [15:0] bcd, bcd0;

  int n_cmp = 0;
  int n_bad = 0;

  score_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .score(score), .seg(seg), .an(an), .dp(dp), .bcd(bcd), .busy(busy));
  score_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut0 (
    .clk(clk), .reset(reset), .score(score), .seg(seg0), .an(an0), .dp(dp0), .bcd(bcd0), .busy(busy0));

  always #5 clk = ~clk;

  // Reference model: displayed number as an integer, pending conversion as a countdown
  int m_k, m_timer, m_pend, m_last, m_disp;
  logic [6:0] m_seg, m_seg0;
  logic [3:0] m_an;

  function automatic int clampv(input logic [31:0] s);
    return (s > 32'd9999) ? 9999 : int'(s);
  endfunction

  function automatic int p10(input int i);
    return (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int i;
    if (!reset) begin
      m_k = 0; m_timer = 0; m_last = 0; m_disp = 0; m_pend = 0;
      m_an = 4'hF; m_seg = 7'h7F; m_seg0 = 7'h7F;
    end else begin
      i = (m_k / 4) % 4;
      m_an   = ~(4'b0001 << i);
      m_seg0 = pat((m_disp / p10(i)) % 10);
      m_seg  = (i > 0 && m_disp < p10(i)) ? 7'h7F : m_seg0;
      m_k++;
      if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) begin m_disp = m_pend; m_last = m_pend; end
      end else if (clampv(score) != m_last) begin
        m_pend = clampv(score); m_timer = 15;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; score = 32'd1234;
    repeat (5) begin
      @(negedge clk);
      n_cmp += 6;
      if (an !== 4'hF)    begin n_bad++; $display("FAIL reset_an: got %h want f", an); end
      if (seg !== 7'h7F)  begin n_bad++; $display("FAIL reset_seg: got %h want 7f", seg); end
      if (dp !== 1'b1)    begin n_bad++; $display("FAIL reset_dp: got %b want 1", dp); end
      if (bcd !== 16'h0)  begin n_bad++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
      if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (an0 !== 4'hF)   begin n_bad++; $display("FAIL reset_an0: got %h want f", an0); end
    end
  endtask

  task automatic test_convert_scan();
    logic [3:0] exp_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    reset = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== (c < 15)) begin n_bad++; $display("FAIL conv_busy@%0d: got %b want %b", c, busy, c < 15); end
      if (c == 14) begin
        n_cmp++;
        if (bcd !== 16'h0) begin n_bad++; $display("FAIL conv_bcd_early: got %h want 0000", bcd); end
      end
      if (c == 15) begin
        n_cmp++;
        if (bcd !== 16'h1234) begin n_bad++; $display("FAIL conv_bcd: got %h want 1234", bcd); end
      end
      if (c >= 16) begin
        n_cmp += 2;
        if (an !== exp_an[(c-16)/4])   begin n_bad++; $display("FAIL scan_an@%0d: got %b want %b", c, an, exp_an[(c-16)/4]); end
        if (seg !== exp_seg[(c-16)/4]) begin n_bad++; $display("FAIL scan_seg@%0d: got %h want %h", c, seg, exp_seg[(c-16)/4]); end
      end
    end
  endtask

  task automatic test_blank();
    score = 32'd42;
    repeat (16) @(negedge clk);
    n_cmp += 2;
    if (bcd !== 16'h0042)  begin n_bad++; $display("FAIL blank_bcd: got %h want 0042", bcd); end
    if (bcd0 !== 16'h0042) begin n_bad++; $display("FAIL blank_bcd0: got %h want 0042", bcd0); end
    repeat (17) begin
      @(negedge clk);
      n_cmp += 4;
      if (an !== m_an)    begin n_bad++; $display("FAIL blank_an: got %b want %b", an, m_an); end
      if (seg !== m_seg)  begin n_bad++; $display("FAIL blank_seg: got %h want %h", seg, m_seg); end
      if (seg0 !== m_seg0) begin n_bad++; $display("FAIL noblank_seg: got %h want %h", seg0, m_seg0); end
      if (an[2] == 1'b0 && seg0 !== 7'h40) begin n_bad++; $display("FAIL noblank_d2: got %h want 40", seg0); end
    end
  endtask

  task automatic test_clamp();
    score = 32'd10000;
    repeat (16) @(negedge clk);
    n_cmp += 2;
    if (bcd !== 16'h9999) begin n_bad++; $display("FAIL clamp_bcd: got %h want 9999", bcd); end
    if (busy !== 1'b0)    begin n_bad++; $display("FAIL clamp_busy: got %b want 0", busy); end
    score = 32'hFFFF_FFFF;
    repeat (20) begin
      @(negedge clk);
      n_cmp += 2;
      if (busy !== 1'b0)    begin n_bad++; $display("FAIL clamp2_busy: got %b want 0", busy); end
      if (bcd !== 16'h9999) begin n_bad++; $display("FAIL clamp2_bcd: got %h want 9999", bcd); end
    end
  endtask

  task automatic test_back_to_back();
    score = 32'd1234;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c == 4) score = 32'd5678;
      if (c == 15 || c == 16 || c == 30 || c == 31) begin
        n_cmp += 2;
        if (bcd !== ((c < 31) ? 16'h1234 : 16'h5678))
          begin n_bad++; $display("FAIL b2b_bcd@%0d: got %h want %h", c, bcd, (c < 31) ? 16'h1234 : 16'h5678); end
        if (busy !== (c == 16 || c == 30))
          begin n_bad++; $display("FAIL b2b_busy@%0d: got %b want %b", c, busy, c == 16 || c == 30); end
      end
    end
  endtask

  task automatic test_reset_mid();
    score = 32'd9999;
    for (int c = 0; c < 7; c++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp += 4;
    if (busy !== 1'b0)   begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (bcd !== 16'h0)   begin n_bad++; $display("FAIL midrst_bcd: got %h want 0000", bcd); end
    if (an !== 4'hF)     begin n_bad++; $display("FAIL midrst_an: got %b want 1111", an); end
    if (seg !== 7'h7F)   begin n_bad++; $display("FAIL midrst_seg: got %h want 7f", seg); end
    reset = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0 || c == 14 || c == 15) begin
        n_cmp += 2;
        if (busy !== (c < 15)) begin n_bad++; $display("FAIL restart_busy@%0d: got %b want %b", c, busy, c < 15); end
        if (bcd !== ((c < 15) ? 16'h0 : 16'h9999))
          begin n_bad++; $display("FAIL restart_bcd@%0d: got %h want %h", c, bcd, (c < 15) ? 16'h0 : 16'h9999); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) reset = 1'b0;
      else reset = 1'b1;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0: score = 32'($urandom_range(0, 99));
          1: score = 32'($urandom_range(0, 9999));
          2: score = $urandom;
          default: score = 32'($urandom_range(9990, 10010));
        endcase
      end
      @(negedge clk);
      n_cmp += 6;
      if (busy !== (m_timer > 0))  begin n_bad++; $display("FAIL rnd_busy@%0d: got %b want %b", c, busy, m_timer > 0); end
      if (bcd !== to_bcd(m_disp))  begin n_bad++; $display("FAIL rnd_bcd@%0d: got %h want %h", c, bcd, to_bcd(m_disp)); end
      if (an !== m_an)             begin n_bad++; $display("FAIL rnd_an@%0d: got %b want %b", c, an, m_an); end
      if (seg !== m_seg)           begin n_bad++; $display("FAIL rnd_seg@%0d: got %h want %h", c, seg, m_seg); end
      if (seg0 !== m_seg0)         begin n_bad++; $display("FAIL rnd_seg0@%0d: got %h want %h", c, seg0, m_seg0); end
      if (dp !== 1'b1)             begin n_bad++; $display("FAIL rnd_dp@%0d: got %b want 1", c, dp); end
    end
  endtask

  initial begin
    test_reset();
    test_convert_scan();
    test_blank();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
